// File: rtl/start_token_sched_if.sv
// Start-token scheduler bus: producer requests, start-FIFO write side, consumer completions, status.
// "master" is the producer/consumer side; "slave" is the scheduler.
interface start_token_sched_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) ();

  logic                sched_en;
  logic [NUM_REQ-1:0]  req_start;
  logic [NUM_REQ-1:0]  req_ack;
  logic                fifo_full_n;
  logic                fifo_write;
  logic [ID_WIDTH-1:0] fifo_din;
  logic                done_valid;
  logic [ID_WIDTH-1:0] done_id;
  logic                busy;
  logic                err_flag;

  modport master (
    output sched_en, req_start, fifo_full_n, done_valid, done_id,
    input  req_ack, fifo_write, fifo_din, busy, err_flag
  );

  modport slave (
    input  sched_en, req_start, fifo_full_n, done_valid, done_id,
    output req_ack, fifo_write, fifo_din, busy, err_flag
  );

endinterface

// File: rtl/start_token_sched.sv
// Round-robin start-token scheduler with per-producer outstanding-token credits.
// Grants are combinational into the start FIFO; credit state, pointer and status are registered.
module start_token_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned MAX_OUT   = 2,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  start_token_sched_if.slave    bus
);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];
  logic [ID_WIDTH-1:0]  last_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 busy_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 grant_vld;
  logic [ID_WIDTH-1:0]  grant_id;
  int unsigned          idx;

  logic                 done_in_range;
  logic                 done_cnt_nz;
  logic                 done_ok;
  logic                 done_bad;

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    elig      = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_start[i] & (cnt_q[i] < CNT_WIDTH'(MAX_OUT)) & bus.sched_en;
    end
    if (reset && bus.fifo_full_n) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (32'(last_q) + k) % NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!grant_vld && (i == idx) && elig[i]) begin
            grant_vld = 1'b1;
            grant_id  = ID_WIDTH'(i);
          end
        end
      end
    end
  end

  always_comb begin
    bus.req_ack    = '0;
    bus.fifo_write = grant_vld;
    bus.fifo_din   = grant_vld ? grant_id : '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ack[i] = grant_vld && (grant_id == ID_WIDTH'(i));
    end
  end

  // A completion is legal only for an existing requester that holds a credit.
  always_comb begin
    done_in_range = 1'b0;
    done_cnt_nz   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.done_id == ID_WIDTH'(i)) begin
        done_in_range = 1'b1;
        done_cnt_nz   = (cnt_q[i] != '0);
      end
    end
    done_ok  = bus.done_valid & done_in_range & done_cnt_nz;
    done_bad = bus.done_valid & ~done_ok;
  end

  always_comb begin
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case ({grant_vld && (grant_id == ID_WIDTH'(i)),
                    done_ok && (bus.done_id == ID_WIDTH'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      busy_d = busy_d | (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '{default: '0};
      last_q <= ID_WIDTH'(NUM_REQ - 1);
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      if (grant_vld) begin
        last_q <= grant_id;
      end
      err_q  <= err_q | done_bad;
      busy_q <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.err_flag = err_q;

endmodule

// File: tb/tb_start_token_sched.sv
// Directed bench for start_token_sched: rotation, backpressure, credits, errors, async reset.
module tb_start_token_sched;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  start_token_sched_if #(.NUM_REQ(4), .ID_WIDTH(2)) bus  ();
  start_token_sched_if #(.NUM_REQ(3), .ID_WIDTH(2)) bus3 ();

  start_token_sched #(.NUM_REQ(4), .ID_WIDTH(2), .MAX_OUT(2), .CNT_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  start_token_sched #(.NUM_REQ(3), .ID_WIDTH(2), .MAX_OUT(2), .CNT_WIDTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    bus.sched_en     = 1'b1;
    bus.req_start    = 4'hF;
    bus.fifo_full_n  = 1'b1;
    bus.done_valid   = 1'b0;
    bus.done_id      = 2'd0;
    bus3.sched_en    = 1'b1;
    bus3.req_start   = 3'b000;
    bus3.fifo_full_n = 1'b1;
    bus3.done_valid  = 1'b0;
    bus3.done_id     = 2'd0;

    // Reset forces outputs low despite pending requests.
    #2;
    check("rst_write", 32'(bus.fifo_write), 32'd0);
    check("rst_ack",   32'(bus.req_ack),    32'd0);
    check("rst_din",   32'(bus.fifo_din),   32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_err",   32'(bus.err_flag),   32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // All requesting: 0,1,2,3,0,1,2,3 then credits exhausted.
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rot_write", 32'(bus.fifo_write), 32'd1);
      check("rot_din",   32'(bus.fifo_din),   32'(i % 4));
      check("rot_ack",   32'(bus.req_ack),    32'(1 << (i % 4)));
      tick();
    end
    #1;
    check("rot_stall_write", 32'(bus.fifo_write), 32'd0);
    check("rot_stall_ack",   32'(bus.req_ack),    32'd0);
    check("rot_busy",        32'(bus.busy),       32'd1);

    // Return every credit.
    bus.req_start = 4'h0;
    for (int id = 0; id < 4; id++) begin
      repeat (2) begin
        bus.done_valid = 1'b1;
        bus.done_id    = 2'(id);
        tick();
      end
    end
    bus.done_valid = 1'b0;
    #1;
    check("drain_busy", 32'(bus.busy),     32'd0);
    check("drain_err",  32'(bus.err_flag), 32'd0);

    // Backpressure, then grant to last_grant+1 that is requesting (1).
    bus.req_start   = 4'b0110;
    bus.fifo_full_n = 1'b0;
    #1;
    check("bp_write", 32'(bus.fifo_write), 32'd0);
    check("bp_ack",   32'(bus.req_ack),    32'd0);
    tick();
    bus.fifo_full_n = 1'b1;
    #1;
    check("bp_rel_write", 32'(bus.fifo_write), 32'd1);
    check("bp_rel_din",   32'(bus.fifo_din),   32'd1);
    check("bp_rel_ack",   32'(bus.req_ack),    32'b0010);
    tick();

    // Credit limit on requester 2.
    bus.req_start = 4'b0100;
    #1;
    check("cred_w1", 32'(bus.fifo_din),   32'd2);
    check("cred_v1", 32'(bus.fifo_write), 32'd1);
    tick();
    #1;
    check("cred_w2", 32'(bus.fifo_din),   32'd2);
    check("cred_v2", 32'(bus.fifo_write), 32'd1);
    tick();
    #1;
    check("cred_stall", 32'(bus.fifo_write), 32'd0);
    bus.done_valid = 1'b1;
    bus.done_id    = 2'd2;
    #1;
    check("cred_same_cycle", 32'(bus.fifo_write), 32'd0);
    tick();
    bus.done_valid = 1'b0;
    #1;
    check("cred_release_v", 32'(bus.fifo_write), 32'd1);
    check("cred_release_d", 32'(bus.fifo_din),   32'd2);
    tick();

    // Grant and completion for requester 1 (cnt=1) in one cycle.
    bus.req_start  = 4'b0010;
    bus.done_valid = 1'b1;
    bus.done_id    = 2'd1;
    #1;
    check("simul_din", 32'(bus.fifo_din), 32'd1);
    check("simul_ack", 32'(bus.req_ack),  32'b0010);
    tick();
    bus.done_valid = 1'b0;
    #1;
    check("simul_cnt_one", 32'(bus.fifo_write), 32'd1);
    check("simul_err",     32'(bus.err_flag),   32'd0);
    tick();
    #1;
    check("simul_cnt_full", 32'(bus.fifo_write), 32'd0);
    bus.req_start = 4'h0;

    // Illegal completion: id 3 holds no credit.
    bus.done_valid = 1'b1;
    bus.done_id    = 2'd3;
    tick();
    bus.done_valid = 1'b0;
    #1;
    check("illegal_err",  32'(bus.err_flag), 32'd1);
    check("illegal_busy", 32'(bus.busy),     32'd1);
    bus.sched_en  = 1'b0;
    bus.req_start = 4'hF;
    #1;
    check("sched_off", 32'(bus.fifo_write), 32'd0);
    bus.sched_en = 1'b1;
    #1;
    check("illegal_cnt3_din", 32'(bus.fifo_din),   32'd3);
    check("illegal_cnt3_v",   32'(bus.fifo_write), 32'd1);
    bus.req_start = 4'h0;
    repeat (3) tick();
    #1;
    check("err_sticky", 32'(bus.err_flag), 32'd1);

    // Three-requester instance: id 3 is out of range.
    check("n3_err_pre", 32'(bus3.err_flag), 32'd0);
    bus3.done_valid = 1'b1;
    bus3.done_id    = 2'd3;
    tick();
    bus3.done_valid = 1'b0;
    #1;
    check("n3_err", 32'(bus3.err_flag), 32'd1);

    // Fill requester 0, then async reset mid-cycle.
    bus.req_start = 4'b0001;
    #1;
    check("fill0_a", 32'(bus.fifo_din), 32'd0);
    tick();
    #1;
    check("fill0_b", 32'(bus.fifo_write), 32'd1);
    tick();
    bus.req_start = 4'hF;
    #1;
    check("pre_rst_write", 32'(bus.fifo_write), 32'd1);
    check("pre_rst_din",   32'(bus.fifo_din),   32'd3);
    reset = 1'b0;
    #1;
    check("async_write", 32'(bus.fifo_write), 32'd0);
    check("async_ack",   32'(bus.req_ack),    32'd0);
    check("async_busy",  32'(bus.busy),       32'd0);
    check("async_err",   32'(bus.err_flag),   32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_din",   32'(bus.fifo_din),   32'd0);
    check("post_rst_ack",   32'(bus.req_ack),    32'b0001);
    check("post_rst_write", 32'(bus.fifo_write), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
